// File: rtl/cs_ctrl_arbiter_if.sv
// Player-control bundle between the input sources (keyboard, two joysticks)
// and the arbitrated ship controls feeding the Computer Space core.
interface cs_ctrl_arbiter_if;
  logic [4:0] kb_ctrl;
  logic [4:0] joy0;
  logic [4:0] joy1;
  logic       signal_ccw;
  logic       signal_cw;
  logic       signal_thrust;
  logic       signal_fire;
  logic       signal_start;
  logic [1:0] owner;

  modport master (
    output kb_ctrl, joy0, joy1,
    input  signal_ccw, signal_cw, signal_thrust, signal_fire, signal_start, owner
  );

  modport slave (
    input  kb_ctrl, joy0, joy1,
    output signal_ccw, signal_cw, signal_thrust, signal_fire, signal_start, owner
  );
endinterface

// File: rtl/cs_ctrl_arbiter.sv
// Control-source arbiter: one source owns the ship controls until it has been
// idle for IDLE_FRAMES frames; start from any source is stretched over frames.
module cs_ctrl_arbiter #(
  parameter int IDLE_FRAMES  = 180,
  parameter int START_FRAMES = 4
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               vs,
  cs_ctrl_arbiter_if.slave   bus
);
  localparam int IW = $clog2(IDLE_FRAMES + 1);
  localparam int SW = $clog2(START_FRAMES + 1);

  typedef enum logic {ST_NONE, ST_OWNED} state_t;

  logic          rst_meta_q, rst_sync_q;
  logic          vs_meta_q, vs_sync_q, vs_prev_q;
  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          ccw_q, ccw_d, cw_q, cw_d, thrust_q, thrust_d, fire_q, fire_d;
  logic          start_prev_q, start_prev_d, start_edge_q, start_edge_d;
  logic [SW-1:0] stretch_cnt_q, stretch_cnt_d;
  logic          start_q, start_d;

  logic       tick, kb_act, joy0_act, joy1_act, owner_act, start_any;
  logic [3:0] sel_bits;

  // Reset asserts asynchronously but is released in step with clk_sys.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      vs_meta_q     <= 1'b0;
      vs_sync_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      state_q       <= ST_NONE;
      owner_q       <= 2'd0;
      idle_cnt_q    <= '0;
      ccw_q         <= 1'b0;
      cw_q          <= 1'b0;
      thrust_q      <= 1'b0;
      fire_q        <= 1'b0;
      start_prev_q  <= 1'b0;
      start_edge_q  <= 1'b0;
      stretch_cnt_q <= '0;
      start_q       <= 1'b0;
    end else begin
      vs_meta_q     <= vs;
      vs_sync_q     <= vs_meta_q;
      vs_prev_q     <= vs_sync_q;
      state_q       <= state_d;
      owner_q       <= owner_d;
      idle_cnt_q    <= idle_cnt_d;
      ccw_q         <= ccw_d;
      cw_q          <= cw_d;
      thrust_q      <= thrust_d;
      fire_q        <= fire_d;
      start_prev_q  <= start_prev_d;
      start_edge_q  <= start_edge_d;
      stretch_cnt_q <= stretch_cnt_d;
      start_q       <= start_d;
    end
  end

  assign tick      = vs_sync_q & ~vs_prev_q;
  assign kb_act    = |bus.kb_ctrl[3:0];
  assign joy0_act  = |bus.joy0[3:0];
  assign joy1_act  = |bus.joy1[3:0];
  assign start_any = bus.kb_ctrl[4] | bus.joy0[4] | bus.joy1[4];

  always_comb begin
    owner_act = 1'b0;
    case (owner_q)
      2'd1:    owner_act = kb_act;
      2'd2:    owner_act = joy0_act;
      2'd3:    owner_act = joy1_act;
      default: owner_act = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_NONE: begin
        idle_cnt_d = '0;
        if (kb_act) begin
          state_d = ST_OWNED;
          owner_d = 2'd1;
        end else if (joy0_act) begin
          state_d = ST_OWNED;
          owner_d = 2'd2;
        end else if (joy1_act) begin
          state_d = ST_OWNED;
          owner_d = 2'd3;
        end
      end
      ST_OWNED: begin
        // Only the owner's own activity keeps the lease alive.
        if (owner_act) begin
          idle_cnt_d = '0;
        end else if (tick) begin
          if (idle_cnt_q == IW'(IDLE_FRAMES - 1)) begin
            state_d    = ST_NONE;
            owner_d    = 2'd0;
            idle_cnt_d = '0;
          end else if (idle_cnt_q != IW'(IDLE_FRAMES)) begin
            idle_cnt_d = idle_cnt_q + IW'(1);
          end
        end
      end
      default: begin
        state_d    = ST_NONE;
        owner_d    = 2'd0;
        idle_cnt_d = '0;
      end
    endcase
  end

  // Movement follows the next owner so grant and release land with owner.
  always_comb begin
    sel_bits = 4'b0000;
    case (owner_d)
      2'd1:    sel_bits = bus.kb_ctrl[3:0];
      2'd2:    sel_bits = bus.joy0[3:0];
      2'd3:    sel_bits = bus.joy1[3:0];
      default: sel_bits = 4'b0000;
    endcase
    ccw_d    = sel_bits[0] & ~sel_bits[1];
    cw_d     = sel_bits[1] & ~sel_bits[0];
    thrust_d = sel_bits[2];
    fire_d   = sel_bits[3];
  end

  always_comb begin
    start_prev_d  = start_any;
    start_edge_d  = start_any & ~start_prev_q;
    stretch_cnt_d = stretch_cnt_q;
    start_d       = start_q;
    // A fresh press only counts when no stretch is running.
    if (start_edge_q && (stretch_cnt_q == '0)) begin
      stretch_cnt_d = SW'(START_FRAMES);
      start_d       = 1'b1;
    end else if (tick && (stretch_cnt_q != '0)) begin
      stretch_cnt_d = stretch_cnt_q - SW'(1);
      if (stretch_cnt_q == SW'(1)) begin
        start_d = 1'b0;
      end
    end
  end

  assign bus.owner         = owner_q;
  assign bus.signal_ccw    = ccw_q;
  assign bus.signal_cw     = cw_q;
  assign bus.signal_thrust = thrust_q;
  assign bus.signal_fire   = fire_q;
  assign bus.signal_start  = start_q;
endmodule
